// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit core's run-control sequencer.
package cpu_pkg;

    localparam int          PC_W             = 16;
    localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;

    // Immediate widths used for branch (8) and jump/JAL (11) offsets.
    localparam int IMM8_W  = 8;
    localparam int IMM11_W = 11;

    // Sequencer state encoding.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_EXEC  = 3'd2;
    localparam logic [2:0] ST_PAUSE = 3'd3;
    localparam logic [2:0] ST_HALT  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_FETCH = ST_FETCH,
        S_EXEC  = ST_EXEC,
        S_PAUSE = ST_PAUSE,
        S_HALT  = ST_HALT
    } state_t;

    // Control-flow flags from the decoder for the instruction in EXEC.
    typedef struct packed {
        logic hlt;
        logic bcc;
        logic bcs;
        logic bne;
        logic beq;
        logic bal;
        logic jmp;
        logic jal_label;
        logic jal_rm;
        logic jr;
    } ctl_flags_t;

endpackage

// File: rtl/next_pc_unit.sv
// Combinational next-PC resolution: flag priority, branch condition, offsets.
module next_pc_unit
    import cpu_pkg::*;
(
    input  logic [PC_W-1:0]    pc,
    input  logic [IMM11_W-1:0] imm,
    input  logic [PC_W-1:0]    rm_data,
    input  ctl_flags_t         flags,
    input  logic               flag_c,
    input  logic               flag_z,
    output logic [PC_W-1:0]    next_pc,
    output logic [PC_W-1:0]    pc_inc,
    output logic               link_req
);

    logic [PC_W-1:0] off8;
    logic [PC_W-1:0] off11;
    logic            br_taken;

    assign pc_inc = pc + 16'd1;
    assign off8   = {{(PC_W-IMM8_W){imm[IMM8_W-1]}}, imm[IMM8_W-1:0]};
    assign off11  = {{(PC_W-IMM11_W){imm[IMM11_W-1]}}, imm};

    assign br_taken = (flags.bcc & ~flag_c) | (flags.bcs &  flag_c)
                    | (flags.bne & ~flag_z) | (flags.beq &  flag_z);

    // HLT never writes the link register even if a JAL flag rides along.
    assign link_req = (flags.jal_label | flags.jal_rm) & ~flags.hlt;

    // Priority chain: HLT > register jumps > long jumps > short branches.
    always_comb begin
        next_pc = pc_inc;
        if (flags.hlt)
            next_pc = pc;
        else if (flags.jr | flags.jal_rm)
            next_pc = rm_data;
        else if (flags.jmp | flags.jal_label)
            next_pc = pc_inc + off11;
        else if (flags.bal | br_taken)
            next_pc = pc_inc + off8;
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Run-control FSM and PC/instruction registers for the 16-bit core.
module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC        = RESET_PC_DEFAULT,
    parameter logic        STEP_EN_DEFAULT = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        step_mode,
    input  logic        step,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic [15:0] instr,
    output logic        instr_valid,
    input  logic        HLT,
    input  logic        BCC,
    input  logic        BCS,
    input  logic        BNE,
    input  logic        BEQ,
    input  logic        Bal,
    input  logic        JMP,
    input  logic        JAL_label_flag,
    input  logic        JAL_Rm_flag,
    input  logic        JR_flag,
    input  logic        flag_c,
    input  logic        flag_z,
    input  logic [15:0] rm_data,
    output logic [15:0] pc,
    output logic        link_we,
    output logic [15:0] link_data,
    output logic        commit,
    output logic        halted
);

    state_t      state, state_nxt;
    logic        step_lat;
    logic        load_rst_pc;
    logic        enter_fetch;
    logic        in_exec;
    logic [15:0] pc_r, instr_r, npc, pc_inc;
    logic        link_req;
    ctl_flags_t  flags;

    assign flags = '{hlt: HLT, bcc: BCC, bcs: BCS, bne: BNE, beq: BEQ, bal: Bal,
                     jmp: JMP, jal_label: JAL_label_flag, jal_rm: JAL_Rm_flag,
                     jr: JR_flag};

    next_pc_unit u_npc (
        .pc       (pc_r),
        .imm      (instr_r[IMM11_W-1:0]),
        .rm_data  (rm_data),
        .flags    (flags),
        .flag_c   (flag_c),
        .flag_z   (flag_z),
        .next_pc  (npc),
        .pc_inc   (pc_inc),
        .link_req (link_req)
    );

    // Next-state logic; start restarts from IDLE, PAUSE and HALT, and beats step.
    always_comb begin
        state_nxt   = state;
        load_rst_pc = 1'b0;
        case (state)
            S_IDLE:  if (start) begin state_nxt = S_FETCH; load_rst_pc = 1'b1; end
            S_FETCH: if (imem_ack) state_nxt = S_EXEC;
            S_EXEC:  begin
                if (HLT)           state_nxt = S_HALT;
                else if (step_lat) state_nxt = S_PAUSE;
                else               state_nxt = S_FETCH;
            end
            S_PAUSE: begin
                if (start)     begin state_nxt = S_FETCH; load_rst_pc = 1'b1; end
                else if (step) state_nxt = S_FETCH;
            end
            S_HALT:  if (start) begin state_nxt = S_FETCH; load_rst_pc = 1'b1; end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign enter_fetch = (state_nxt == S_FETCH) && (state != S_FETCH);
    assign in_exec     = (state == S_EXEC);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // PC, fetched word and step latch; the latch re-samples on each FETCH entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r     <= RESET_PC;
            instr_r  <= 16'h0000;
            step_lat <= STEP_EN_DEFAULT;
        end else begin
            if (load_rst_pc)  pc_r <= RESET_PC;
            else if (in_exec) pc_r <= npc;
            if (state == S_FETCH && imem_ack) instr_r <= imem_rdata;
            if (enter_fetch) step_lat <= step_mode;
        end
    end

    assign imem_req    = (state == S_FETCH);
    assign imem_addr   = pc_r;
    assign pc          = pc_r;
    assign instr       = instr_r;
    assign instr_valid = in_exec;
    assign commit      = in_exec;
    assign link_we     = in_exec & link_req;
    assign link_data   = in_exec ? pc_inc : 16'h0000;
    assign halted      = (state == S_HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer with a flag-priority reference model.
module tb_fetch_sequencer;

    localparam logic [15:0] RST_PC = 16'h0000;
    localparam int F_HLT = 0, F_BCC = 1, F_BCS = 2, F_BNE = 3, F_BEQ = 4;
    localparam int F_BAL = 5, F_JMP = 6, F_JALL = 7, F_JALR = 8, F_JR = 9;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        start = 1'b0, step_mode = 1'b0, step = 1'b0, imem_ack = 1'b0;
    logic [15:0] imem_rdata = 16'h0, rm_data = 16'h0;
    logic        flag_c = 1'b0, flag_z = 1'b0;
    logic [9:0]  fl = '0;
    logic        imem_req, instr_valid, link_we, commit, halted;
    logic [15:0] imem_addr, instr, pc, link_data;

    int total = 0;
    int bad   = 0;

    // Observations captured by the instruction driver.
    logic        ob_got_req, ob_commit, ob_valid, ob_lwe;
    int          ob_stall_bad;
    logic [15:0] ob_addr, ob_ldata, ob_instr, ob_pc_after;

    always #5 clk = ~clk;

    fetch_sequencer #(.RESET_PC(RST_PC), .STEP_EN_DEFAULT(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .step_mode(step_mode), .step(step),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .instr(instr), .instr_valid(instr_valid),
        .HLT(fl[F_HLT]), .BCC(fl[F_BCC]), .BCS(fl[F_BCS]), .BNE(fl[F_BNE]),
        .BEQ(fl[F_BEQ]), .Bal(fl[F_BAL]), .JMP(fl[F_JMP]),
        .JAL_label_flag(fl[F_JALL]), .JAL_Rm_flag(fl[F_JALR]), .JR_flag(fl[F_JR]),
        .flag_c(flag_c), .flag_z(flag_z), .rm_data(rm_data), .pc(pc),
        .link_we(link_we), .link_data(link_data), .commit(commit), .halted(halted)
    );

    // Reference next PC from the architectural rules, using signed integer offsets.
    function automatic logic [15:0] ref_next(input logic [15:0] p, input logic [15:0] w,
                                             input logic [9:0] f, input logic c, input logic z,
                                             input logic [15:0] rm);
        int t, o11, o8;
        logic [31:0] tv;
        o11 = int'(w[10:0]); if (o11 >= 1024) o11 -= 2048;
        o8  = int'(w[7:0]);  if (o8 >= 128)   o8  -= 256;
        if (f[F_HLT])                                      t = int'(p);
        else if (f[F_JR] || f[F_JALR])                     t = int'(rm);
        else if (f[F_JMP] || f[F_JALL])                    t = int'(p) + 1 + o11;
        else if (f[F_BAL] || (f[F_BCC] && !c) || (f[F_BCS] && c) ||
                 (f[F_BNE] && !z) || (f[F_BEQ] && z))      t = int'(p) + 1 + o8;
        else                                               t = int'(p) + 1;
        tv = t;
        return tv[15:0];
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; start = 1'b0; step = 1'b0; step_mode = 1'b0; imem_ack = 1'b0;
        fl = '0; flag_c = 1'b0; flag_z = 1'b0; rm_data = 16'h0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Drives one fetch (with optional stall) and its EXEC cycle; records observations.
    task automatic exec_instr(input logic [15:0] w, input logic [9:0] f, input logic c,
                              input logic z, input logic [15:0] rm, input int stall);
        logic [15:0] p0;
        ob_got_req = 1'b0; ob_stall_bad = 0;
        for (int i = 0; i < 20 && !ob_got_req; i++) begin
            if (imem_req === 1'b1) ob_got_req = 1'b1;
            else @(negedge clk);
        end
        ob_addr = imem_addr; p0 = pc;
        for (int i = 0; i < stall; i++) begin
            imem_ack = 1'b0;
            @(negedge clk);
            if (imem_req !== 1'b1 || commit !== 1'b0 || pc !== p0) ob_stall_bad++;
        end
        imem_ack = 1'b1; imem_rdata = w; fl = f; flag_c = c; flag_z = z; rm_data = rm;
        @(negedge clk);
        imem_ack = 1'b0;
        ob_commit = commit; ob_valid = instr_valid; ob_lwe = link_we;
        ob_ldata = link_data; ob_instr = instr;
        @(negedge clk);
        ob_pc_after = pc;
        fl = '0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got %b want 0", imem_req); end total++;
        if (pc !== RST_PC) begin bad++; $display("FAIL rst_pc got %h want %h", pc, RST_PC); end total++;
        if (instr !== 16'h0) begin bad++; $display("FAIL rst_instr got %h want 0000", instr); end total++;
        if ({instr_valid, commit, link_we, halted} !== 4'b0) begin
            bad++; $display("FAIL rst_ctl got %b want 0000", {instr_valid, commit, link_we, halted});
        end total++;
        if (link_data !== 16'h0) begin bad++; $display("FAIL rst_ldata got %h want 0000", link_data); end total++;
        rst_n = 1'b1;
        imem_ack = 1'b1; imem_rdata = 16'hBEEF;
        @(negedge clk); @(negedge clk);
        imem_ack = 1'b0;
        if (imem_req !== 1'b0 || instr !== 16'h0) begin
            bad++; $display("FAIL idle_ack got req=%b instr=%h want 0/0000", imem_req, instr);
        end total++;
        pulse_start();
        if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
            bad++; $display("FAIL start_fetch got req=%b addr=%h want 1/%h", imem_req, imem_addr, RST_PC);
        end total++;
        #2 rst_n = 1'b0;
        #1;
        if (imem_req !== 1'b0) begin bad++; $display("FAIL async_rst_req got %b want 0", imem_req); end total++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_sequential();
        do_reset();
        imem_ack = 1'b1; imem_rdata = 16'h1234; fl = '0;
        pulse_start();
        for (int k = 0; k < 6; k++) begin
            logic        e_commit;
            logic [15:0] e_pc;
            e_commit = (k % 2) == 1;
            e_pc     = 16'(k / 2);
            if (commit !== e_commit || imem_req !== !e_commit) begin
                bad++; $display("FAIL seq_cycle%0d got commit=%b req=%b want %b/%b", k, commit, imem_req, e_commit, !e_commit);
            end total++;
            if (pc !== e_pc || imem_addr !== e_pc) begin
                bad++; $display("FAIL seq_pc%0d got pc=%h addr=%h want %h", k, pc, imem_addr, e_pc);
            end total++;
            @(negedge clk);
        end
        imem_ack = 1'b0;
    endtask

    task automatic test_branches();
        logic [9:0]  bf [3];
        logic        bz [3];
        logic [15:0] bexp [3];
        bf[0] = 10'b1 << F_BEQ; bz[0] = 1'b1; bexp[0] = 16'h000D;
        bf[1] = 10'b1 << F_BEQ; bz[1] = 1'b0; bexp[1] = 16'h0011;
        bf[2] = 10'b1 << F_BCC; bz[2] = 1'b0; bexp[2] = 16'h000D;
        for (int i = 0; i < 3; i++) begin
            do_reset();
            pulse_start();
            exec_instr(16'h000F, 10'b1 << F_JMP, 1'b0, 1'b0, 16'h0, 0);
            if (ob_pc_after !== 16'h0010) begin bad++; $display("FAIL br_setup%0d got %h want 0010", i, ob_pc_after); end total++;
            exec_instr(16'h00FC, bf[i], 1'b0, bz[i], 16'h0, 0);
            if (ob_pc_after !== bexp[i]) begin bad++; $display("FAIL br_case%0d got %h want %h", i, ob_pc_after, bexp[i]); end total++;
        end
    endtask

    task automatic test_jal();
        do_reset();
        pulse_start();
        exec_instr(16'h0000, 10'b1 << F_JR, 1'b0, 1'b0, 16'h0020, 0);
        exec_instr(16'h0010, 10'b1 << F_JALL, 1'b0, 1'b0, 16'h0, 0);
        if (ob_lwe !== 1'b1 || ob_ldata !== 16'h0021) begin
            bad++; $display("FAIL jal_link got we=%b data=%h want 1/0021", ob_lwe, ob_ldata);
        end total++;
        if (ob_pc_after !== 16'h0031) begin bad++; $display("FAIL jal_pc got %h want 0031", ob_pc_after); end total++;
        exec_instr(16'h0000, 10'b1 << F_JR, 1'b0, 1'b0, 16'h0021, 0);
        if (ob_lwe !== 1'b0 || ob_pc_after !== 16'h0021) begin
            bad++; $display("FAIL jr got we=%b pc=%h want 0/0021", ob_lwe, ob_pc_after);
        end total++;
    endtask

    task automatic test_wrap_stall();
        do_reset();
        pulse_start();
        exec_instr(16'h0000, 10'b1 << F_JR, 1'b0, 1'b0, 16'hFFFF, 0);
        exec_instr(16'h5555, '0, 1'b0, 1'b0, 16'h0, 5);
        if (ob_got_req !== 1'b1 || ob_stall_bad != 0) begin
            bad++; $display("FAIL stall got req=%b bad_cycles=%0d want 1/0", ob_got_req, ob_stall_bad);
        end total++;
        if (ob_addr !== 16'hFFFF || ob_pc_after !== 16'h0000) begin
            bad++; $display("FAIL wrap got addr=%h pc=%h want FFFF/0000", ob_addr, ob_pc_after);
        end total++;
    endtask

    task automatic test_halt();
        int reqs;
        do_reset();
        pulse_start();
        exec_instr(16'h0004, 10'b1 << F_JMP, 1'b0, 1'b0, 16'h0, 0);
        exec_instr(16'h0000, (10'b1 << F_HLT) | (10'b1 << F_JALL), 1'b0, 1'b0, 16'h0, 0);
        if (ob_lwe !== 1'b0 || ob_commit !== 1'b1) begin
            bad++; $display("FAIL hlt_exec got we=%b commit=%b want 0/1", ob_lwe, ob_commit);
        end total++;
        if (halted !== 1'b1 || ob_pc_after !== 16'h0005) begin
            bad++; $display("FAIL hlt_state got halted=%b pc=%h want 1/0005", halted, ob_pc_after);
        end total++;
        reqs = 0;
        imem_ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (imem_req === 1'b1 || halted !== 1'b1 || pc !== 16'h0005) reqs++;
        end
        imem_ack = 1'b0;
        if (reqs != 0) begin bad++; $display("FAIL hlt_hold got %0d bad cycles want 0", reqs); end total++;
        pulse_start();
        if (halted !== 1'b0 || imem_req !== 1'b1 || pc !== RST_PC) begin
            bad++; $display("FAIL hlt_restart got halted=%b req=%b pc=%h want 0/1/%h", halted, imem_req, pc, RST_PC);
        end total++;
    endtask

    task automatic test_step();
        int cnt, reqs;
        logic [15:0] mpc;
        do_reset();
        step_mode = 1'b1;
        pulse_start();
        exec_instr(16'h0000, '0, 1'b0, 1'b0, 16'h0, 0);
        mpc = 16'h0001;
        reqs = 0;
        for (int i = 0; i < 4; i++) begin
            if (imem_req !== 1'b0 || commit !== 1'b0) reqs++;
            @(negedge clk);
        end
        if (reqs != 0 || pc !== mpc) begin
            bad++; $display("FAIL pause_hold got %0d bad cycles pc=%h want 0/%h", reqs, pc, mpc);
        end total++;
        for (int s = 0; s < 3; s++) begin
            step = 1'b1;
            @(negedge clk);
            step = 1'b0;
            exec_instr(16'($urandom), '0, 1'b0, 1'b0, 16'h0, $urandom_range(0, 2));
            cnt = ob_commit ? 1 : 0;
            for (int i = 0; i < 4; i++) begin
                if (commit === 1'b1) cnt++;
                @(negedge clk);
            end
            mpc = mpc + 16'd1;
            if (cnt != 1 || pc !== mpc) begin
                bad++; $display("FAIL step%0d got commits=%0d pc=%h want 1/%h", s, cnt, pc, mpc);
            end total++;
        end
        step = 1'b1; start = 1'b1;
        @(negedge clk);
        step = 1'b0; start = 1'b0;
        if (pc !== RST_PC || imem_req !== 1'b1) begin
            bad++; $display("FAIL step_start got pc=%h req=%b want %h/1", pc, imem_req, RST_PC);
        end total++;
        step_mode = 1'b0;
    endtask

    task automatic test_random();
        logic [15:0] mpc, w, rm, e_pc;
        logic [9:0]  f;
        logic        c, z, e_lwe;
        do_reset();
        pulse_start();
        mpc = RST_PC;
        for (int n = 0; n < 40; n++) begin
            int r;
            r = $urandom_range(0, 9);
            f = '0;
            if (r != F_HLT) f[r] = 1'b1;
            if ($urandom_range(0, 3) == 0) f[$urandom_range(1, 9)] = 1'b1;
            w = 16'($urandom); rm = 16'($urandom);
            c = 1'($urandom); z = 1'($urandom);
            e_pc  = ref_next(mpc, w, f, c, z, rm);
            e_lwe = f[F_JALL] | f[F_JALR];
            exec_instr(w, f, c, z, rm, $urandom_range(0, 2));
            if (ob_addr !== mpc || ob_instr !== w || ob_valid !== 1'b1) begin
                bad++; $display("FAIL rnd%0d_fetch got addr=%h instr=%h vld=%b want %h/%h/1", n, ob_addr, ob_instr, ob_valid, mpc, w);
            end total++;
            if (ob_lwe !== e_lwe || (e_lwe && ob_ldata !== 16'(mpc + 16'd1))) begin
                bad++; $display("FAIL rnd%0d_link got we=%b data=%h want %b/%h", n, ob_lwe, ob_ldata, e_lwe, 16'(mpc + 16'd1));
            end total++;
            if (ob_pc_after !== e_pc) begin
                bad++; $display("FAIL rnd%0d_pc flags=%b got %h want %h", n, f, ob_pc_after, e_pc);
            end total++;
            mpc = e_pc;
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branches();
        test_jal();
        test_wrap_stall();
        test_halt();
        test_step();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Run-control and program-counter sequencer for the 16-bit RISC core. It fetches from instruction memory using a req/ack handshake and holds the fetched word for the instruction decoder. It takes the decoder's control-flow flags back and resolves the next PC for branches, jumps, JAL and JR. It also produces the link value, the per-instruction commit strobe, and halt / single-step control.

Parameters:
RESET_PC, 16'h0000, PC loaded on reset and on start.
STEP_EN_DEFAULT, 1'b0, reset value of the internal step-mode latch.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  pulse; begins or restarts execution at RESET_PC.
step_mode  in  1  level; 1 = pause after every committed instruction.
step  in  1  pulse; releases one instruction while paused.
imem_req  out  1  fetch request.
imem_addr  out  16  word address, equal to pc.
imem_ack  in  1  memory returns imem_rdata this cycle.
imem_rdata  in  16  fetched instruction word.
instr  out  16  registered instruction to the decoder.
instr_valid  out  1  high in EXEC only; gates all writebacks.
HLT, BCC, BCS, BNE, BEQ, Bal, JMP, JAL_label_flag, JAL_Rm_flag, JR_flag  in  1 each  decoder flags for instr.
flag_c, flag_z  in  1 each  current carry and zero flags.
rm_data  in  16  register-file read of Rm, used by JAL_Rm and JR.
pc  out  16  current PC.
link_we  out  1  writes link_data to the link register.
link_data  out  16  pc+1.
commit  out  1  one-cycle pulse per retired instruction.
halted  out  1  high in HALT.

Behaviour:
- Reset (asynchronous, rst_n=0) forces: state=IDLE, pc=RESET_PC, instr=16'h0000, step latch=STEP_EN_DEFAULT. All other outputs are 0.
- The step latch samples step_mode on every transition into FETCH.
- States:
  - IDLE: on start, pc<=RESET_PC, go to FETCH.
  - FETCH: imem_req=1, imem_addr=pc. On imem_ack, instr<=imem_rdata and go to EXEC. Otherwise stay; wait time is unbounded.
  - EXEC: lasts exactly one cycle. instr_valid=1 and commit=1. pc<=next_pc. Next state is HALT if HLT; else PAUSE if the step latch is set; else FETCH.
  - PAUSE: pc holds. step goes to FETCH; start goes to FETCH with pc<=RESET_PC.
  - HALT: halted=1. Only start (restart at RESET_PC) or reset leaves HALT.
- Minimum latency is 2 cycles per instruction (ack in the first FETCH cycle).
- next_pc selection in EXEC, highest priority first:
  - HLT: pc (unchanged).
  - JR_flag or JAL_Rm_flag: rm_data.
  - JMP or JAL_label_flag: pc+1+sext(instr[10:0]).
  - Bal: pc+1+sext(instr[7:0]).
  - Conditional branch, taken when BCC&!flag_c, BCS&flag_c, BNE&!flag_z, or BEQ&flag_z: pc+1+sext(instr[7:0]).
  - Otherwise: pc+1.
- All PC arithmetic is modulo 2^16: 16'hFFFF+1 = 16'h0000, and negative offsets wrap below 0.
- link_we=1 only in EXEC when JAL_label_flag or JAL_Rm_flag is set. link_data=pc+1, computed before the PC update.
- If several flags are asserted at once, the priority above applies. Link is still written for JAL even if a higher-priority flag is set, except HLT, which suppresses link_we.
- Simultaneous start and step in PAUSE: start wins.
- start in FETCH or EXEC is ignored.
- imem_ack outside FETCH is ignored.
- Reset asserted mid-fetch drops imem_req immediately (asynchronous). The pending fetch is abandoned.

Decomposition:
- Shared package cpu_pkg holds:
  - state encoding localparams ST_IDLE, ST_FETCH, ST_EXEC, ST_PAUSE, ST_HALT;
  - RESET_PC default;
  - sign-extension widths IMM8_W=8 and IMM11_W=11.
- One sub-module, next_pc_unit: combinational flag priority, condition evaluation, sign extension, and adders. The FSM and registers stay in fetch_sequencer.

Test Plan:
1. Sequential fetch: start, ack every cycle, no flags set. Required: pc runs 0000,0001,0002; commit pulses every 2 cycles; imem_addr equals pc.
2. Branches at pc=0010, instr[7:0]=8'hFC:
   - BEQ with flag_z=1: next pc=000D.
   - BEQ with flag_z=0: next pc=0011.
   - BCC with flag_c=0: next pc=000D.
3. JAL_label at pc=0020, instr[10:0]=11'h010: pc=0031, link_we=1, link_data=0021. Then JR with rm_data=0021: pc=0021, link_we=0.
4. Wrap and stall: at pc=FFFF with no flags, next pc=0000. Hold imem_ack low for 5 cycles: required FETCH held, imem_req=1, commit=0, pc stable.
5. Halt: HLT at pc=0005 gives halted=1, pc=0005, no further imem_req. start then restarts at 0000.
6. Step mode: step_mode=1, start. Required: after one commit, state is PAUSE with imem_req=0. Each step pulse yields exactly one commit. With step and start asserted together, pc=RESET_PC.
